// File: rtl/ets_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ets_sweep_ctrl
// Description : Equivalent-time sampling sweep controller. For each phase
//               step it requests a clock phase shift, waits for settling,
//               counts comparator ones over a fixed window and streams one
//               {step, ones} word per step.
// Revision    : 1.0 - initial release
// ============================================================================
module ets_sweep_ctrl #(
  parameter int CNT_W   = 16,
  parameter int TMO_CYC = 65535
) (
  input  logic             sample_clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_steps,
  input  logic [CNT_W-1:0] acq_len,
  input  logic [7:0]       settle_len,
  input  logic             cmp_data,
  output logic             shift,
  input  logic             shift_done,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic [31:0]      m_tdata,
  output logic             m_tlast,
  output logic             busy,
  output logic             done,
  output logic             err
);

  // Timeout counter runs 0 .. TMO_CYC-1 while in SHIFT.
  localparam int TMO_W = (TMO_CYC < 2) ? 1 : $clog2(TMO_CYC);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SHIFT  = 3'd1,
    SETTLE = 3'd2,
    ACQ    = 3'd3,
    EMIT   = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t             state;
  state_t             state_nxt;

  logic [CNT_W-1:0]   num_steps_q;
  logic [CNT_W-1:0]   acq_len_q;     // already forced to >= 1
  logic [7:0]         settle_q;
  logic [CNT_W-1:0]   step;
  logic [CNT_W-1:0]   ones;
  logic [CNT_W-1:0]   acq_cnt;
  logic [7:0]         settle_cnt;
  logic [TMO_W-1:0]   tmo_cnt;
  logic               cmp_q;
  logic               err_q;
  logic               last_step;

  assign last_step = (step == (num_steps_q - CNT_W'(1)));

  // State register.
  always_ff @(posedge sample_clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; step 0 skips the phase shift entirely.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (num_steps == '0) ? DONE : ACQ;
        end
      end
      SHIFT: begin
        if (shift_done) begin
          state_nxt = (settle_q == 8'd0) ? ACQ : SETTLE;
        end else if (tmo_cnt == TMO_LAST) begin
          state_nxt = DONE;
        end
      end
      SETTLE: begin
        if (settle_cnt == (settle_q - 8'd1)) begin
          state_nxt = ACQ;
        end
      end
      ACQ: begin
        if (acq_cnt == (acq_len_q - CNT_W'(1))) begin
          state_nxt = EMIT;
        end
      end
      EMIT: begin
        if (m_tready) begin
          state_nxt = last_step ? DONE : SHIFT;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: parameter latching, step/ones/window/settle/timeout counters.
  always_ff @(posedge sample_clk) begin
    if (rst) begin
      num_steps_q <= '0;
      acq_len_q   <= '0;
      settle_q    <= '0;
      step        <= '0;
      ones        <= '0;
      acq_cnt     <= '0;
      settle_cnt  <= '0;
      tmo_cnt     <= '0;
      cmp_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      cmp_q <= cmp_data;

      if (state == IDLE && start) begin
        num_steps_q <= num_steps;
        acq_len_q   <= (acq_len == '0) ? CNT_W'(1) : acq_len;
        settle_q    <= settle_len;
        step        <= '0;
        err_q       <= 1'b0;
      end

      if (state == EMIT && m_tready && !last_step) begin
        step <= step + CNT_W'(1);
      end

      if (state == SHIFT && !shift_done && tmo_cnt == TMO_LAST) begin
        err_q <= 1'b1;
      end

      // Window counters restart on every ACQ entry; ones is held through EMIT.
      if (state_nxt == ACQ && state != ACQ) begin
        ones    <= '0;
        acq_cnt <= '0;
      end else if (state == ACQ) begin
        acq_cnt <= acq_cnt + CNT_W'(1);
        if (cmp_q) begin
          ones <= ones + CNT_W'(1);
        end
      end

      if (state_nxt == SETTLE && state != SETTLE) begin
        settle_cnt <= 8'd0;
      end else if (state == SETTLE) begin
        settle_cnt <= settle_cnt + 8'd1;
      end

      if (state_nxt == SHIFT && state != SHIFT) begin
        tmo_cnt <= '0;
      end else if (state == SHIFT) begin
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      end
    end
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    shift    = (state == SHIFT);
    m_tvalid = (state == EMIT);
    m_tlast  = (state == EMIT) && last_step;
    m_tdata  = {step[15:0], ones[15:0]};
    busy     = (state != IDLE);
    done     = (state == DONE);
    err      = err_q;
  end

endmodule
`default_nettype wire

// File: doc/ets_sweep_ctrl.md
ETS_SWEEP_CTRL -- requirements
Module: ets_sweep_ctrl

Interface
REQ-001 Parameter: CNT_W, 16, width of step index, acquisition length and ones-count fields.
REQ-002 Parameter: TMO_CYC, 65535, max cycles to wait for shift_done before aborting.
REQ-003 sample_clk  in  1  sole clock; all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 start  in  1  sweep request; sampled only in IDLE.
REQ-006 num_steps  in  CNT_W  phase steps per sweep; latched on accepted start.
REQ-007 acq_len  in  CNT_W  comparator cycles counted per step; latched on accepted start.
REQ-008 settle_len  in  8  idle cycles after each phase shift; latched on accepted start.
REQ-009 cmp_data  in  1  comparator output.
REQ-010 shift  out  1  phase-shift request to clock source.
REQ-011 shift_done  in  1  clock source acknowledge.
REQ-012 m_tvalid / m_tready / m_tdata[31:0] / m_tlast  out/in/out/out  result stream, one word per step.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 done  out  1  one-cycle pulse at sweep end.
REQ-015 err  out  1  sticky shift-timeout flag; cleared by next accepted start or reset.

Function
REQ-016 FSM states: IDLE, SHIFT, SETTLE, ACQ, EMIT, DONE.
REQ-017 IDLE: start=1 latches num_steps, acq_len, settle_len, clears step index, clears err; next state ACQ (step 0 takes no shift); num_steps=0 goes to DONE with no stream output.
REQ-018 SHIFT: shift=1 held continuously until shift_done sampled 1; then SETTLE; shift_done ignored in all other states.
REQ-019 SHIFT timeout: TMO_CYC cycles in SHIFT without shift_done sets err, drops shift, goes to DONE; no further words emitted.
REQ-020 SETTLE: lasts exactly settle_len cycles (0 = zero cycles, SHIFT goes direct to ACQ), then ACQ.
REQ-021 cmp_data registered once (cmp_q); ACQ counts cmp_q==1 over exactly acq_len cycles; acq_len=0 treated as 1.
REQ-022 Ones counter CNT_W wide, cleared on ACQ entry; max value acq_len, no overflow possible.
REQ-023 EMIT: m_tvalid=1, m_tdata={step[15:0], ones[15:0]}, m_tlast=1 iff step==num_steps-1.
REQ-024 m_tdata/m_tlast stable while m_tvalid=1 and m_tready=0; m_tvalid never deasserted before handshake.
REQ-025 On handshake: if last step -> DONE, else step+1 and -> SHIFT.
REQ-026 DONE: done=1 for one cycle, then IDLE; busy falls the cycle IDLE is entered.
REQ-027 start while busy ignored; no queuing.
REQ-028 Latency from shift_done to first ACQ count cycle: settle_len+1 cycles.
REQ-029 Input changes on num_steps/acq_len/settle_len after start have no effect until next sweep.

Reset
REQ-030 rst=1 at an edge forces IDLE; shift, m_tvalid, m_tlast, busy, done, err, counters, step, cmp_q all 0 at next edge.
REQ-031 Reset mid-sweep (any state, incl. SHIFT with shift high or EMIT with tvalid high) aborts with no done pulse and no partial word completion.

Verification
REQ-032 num_steps=3, acq_len=10, settle_len=2, cmp_data=1, tready=1, shift_done 4 cycles after shift -> words 0x0000000A, 0x0001000A, 0x0002000A, tlast on third, two shift pulses, done once.
REQ-033 acq_len=8, cmp_data toggling every cycle, num_steps=1 -> one word 0x00000004 with tlast, no shift issued.
REQ-034 tready=0 for 20 cycles in EMIT -> tvalid/tdata held constant, no state advance; resume on tready=1.
REQ-035 shift_done never asserted, TMO_CYC=100 override -> err=1 after 100 SHIFT cycles, shift low, done pulse, only step-0 word emitted.
REQ-036 rst asserted during SHIFT of step 1 -> shift=0, busy=0 next cycle, no done; new start runs full sweep correctly with err cleared.
REQ-037 start asserted while busy and num_steps=0 in IDLE -> first ignored; second yields done pulse, no stream words.
